// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - EXE-stage divider request/result bundle
interface div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             div_req;
  logic             div_signed;
  logic [WIDTH-1:0] div_src1;
  logic [WIDTH-1:0] div_src2;
  logic             div_cancel;
  logic             div_stall;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;
  logic [1:0]       hl_we;
  logic [WIDTH-1:0] h_wdata;
  logic [WIDTH-1:0] l_wdata;

  modport master (
    output div_req, div_signed, div_src1, div_src2, div_cancel,
    input  div_stall, div_busy, div_done, div_quot, div_rem, hl_we, h_wdata, l_wdata
  );

  modport slave (
    input  div_req, div_signed, div_src1, div_src2, div_cancel,
    output div_stall, div_busy, div_done, div_quot, div_rem, hl_we, h_wdata, l_wdata
  );
endinterface

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - iterative radix-2 restoring divider with EXE stall/HI-LO sequencing
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  div_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic             q_sign;
  logic             r_sign;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH:0]   upper;
  logic             ge;
  logic [WIDTH-1:0] prem_n;
  logic [WIDTH-1:0] dvd_n;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic             last;

  // dvd doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom
  assign upper  = {prem, dvd[WIDTH-1]};
  assign ge     = upper >= {1'b0, dvs};
  assign prem_n = ge ? (upper[WIDTH-1:0] - dvs) : upper[WIDTH-1:0];
  assign dvd_n  = {dvd[WIDTH-2:0], ge};

  assign abs1 = (bus.div_signed && bus.div_src1[WIDTH-1]) ? -bus.div_src1 : bus.div_src1;
  assign abs2 = (bus.div_signed && bus.div_src2[WIDTH-1]) ? -bus.div_src2 : bus.div_src2;
  assign last = (state == S_CALC) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (bus.div_req) state_n = S_CALC;
      S_CALC:  if (last)        state_n = S_DONE;
      S_DONE:                   state_n = S_IDLE;
      default:                  state_n = S_IDLE;
    endcase
    if (bus.div_cancel) state_n = S_IDLE;

    bus.div_stall = reset & (((state == S_IDLE) & bus.div_req & ~bus.div_cancel) | (state == S_CALC));
    bus.div_busy  = reset & ((state == S_CALC) | (state == S_DONE));
    bus.div_done  = reset & (state == S_DONE) & ~bus.div_cancel;
    bus.hl_we     = {2{bus.div_done}};
    bus.div_quot  = quot_q;
    bus.div_rem   = rem_q;
    bus.h_wdata   = rem_q;
    bus.l_wdata   = quot_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      prem   <= '0;
      q_sign <= 1'b0;
      r_sign <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else if (bus.div_cancel) begin
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.div_req) begin
          dvd    <= abs1;
          dvs    <= abs2;
          prem   <= '0;
          cnt    <= '0;
          q_sign <= bus.div_signed & (bus.div_src1[WIDTH-1] ^ bus.div_src2[WIDTH-1]);
          r_sign <= bus.div_signed & bus.div_src1[WIDTH-1];
        end
        S_CALC: begin
          dvd  <= dvd_n;
          prem <= prem_n;
          cnt  <= cnt + CW'(1);
          // sign fix-up lands together with the final step so results are ready in DONE
          if (last) begin
            quot_q <= q_sign ? -dvd_n  : dvd_n;
            rem_q  <= r_sign ? -prem_n : prem_n;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
